// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one RAM port between instruction fetch (read-only) and the memory stage.
//   clk, rst                           : clock, asynchronous active-high reset
//   if_req, if_addr                    : fetch request, held until if_gnt
//   if_gnt, if_rvalid, if_rdata        : fetch grant, response pulse, registered read data
//   m_req, m_we, m_funct, m_addr, m_wdata : memory-stage request, held until m_gnt
//   m_gnt, m_rvalid, m_rdata           : memory-stage grant, response pulse, registered load data
//   ram_en, ram_we, ram_funct, ram_addr, ram_wdata, ram_rdata : RAM command and read return
//   busy                               : a transaction is in progress
module mem_port_arbiter #(
    parameter int RAM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        m_req,
    input  logic        m_we,
    input  logic [9:0]  m_funct,
    input  logic [31:0] m_addr,
    input  logic [31:0] m_wdata,
    output logic        m_gnt,
    output logic        m_rvalid,
    output logic [31:0] m_rdata,
    output logic        ram_en,
    output logic        ram_we,
    output logic [9:0]  ram_funct,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata,
    output logic        busy
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;
    logic [1:0]  r_state;
    logic        r_owner;
    logic [3:0]  r_cnt;
    logic [2:0]  r_starve;
    logic        r_we;
    logic [9:0]  r_funct;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_if_rdata;
    logic [31:0] r_m_rdata;
    logic        w_win;
    logic        w_m_gnt;
    logic        w_if_gnt;
    logic        w_cap;
    logic        w_active;
    assign w_win    = r_state == IDLE || r_state == RESP;
    // Fetch wins over a competing memory request once it has lost STARVE_LIMIT grants in a row
    assign w_m_gnt  = w_win && m_req && !(if_req && r_starve == 3'(STARVE_LIMIT));
    assign w_if_gnt = w_win && if_req && !w_m_gnt;
    assign w_active = r_state == ISSUE || r_state == WAIT;
    // cnt reaches 0 in the cycle the RAM read data is valid
    assign w_cap    = w_active && r_cnt == 4'd0;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_owner    <= 1'b0;
            r_cnt      <= 4'd0;
            r_starve   <= 3'd0;
            r_we       <= 1'b0;
            r_funct    <= 10'd0;
            r_addr     <= 32'd0;
            r_wdata    <= 32'd0;
            r_if_rdata <= 32'd0;
            r_m_rdata  <= 32'd0;
        end else begin
            if (w_cap && !r_owner)
                r_if_rdata <= ram_rdata;
            if (w_cap && r_owner && !r_we)
                r_m_rdata <= ram_rdata;
            if (w_m_gnt || w_if_gnt) begin
                r_state  <= ISSUE;
                r_owner  <= w_m_gnt;
                r_cnt    <= 4'(RAM_LATENCY - 1);
                r_we     <= w_m_gnt && m_we;
                r_funct  <= w_m_gnt ? m_funct : 10'd0;
                r_addr   <= w_m_gnt ? m_addr : if_addr;
                r_wdata  <= w_m_gnt ? m_wdata : 32'd0;
                r_starve <= w_if_gnt ? 3'd0 :
                            (if_req && r_starve != 3'(STARVE_LIMIT)) ? r_starve + 3'd1 : r_starve;
            end else if (w_cap) begin
                r_state <= RESP;
            end else if (w_active) begin
                r_state <= WAIT;
                r_cnt   <= r_cnt - 4'd1;
            end else begin
                r_state <= IDLE;
            end
        end
    end
    // Grants are combinational; mask them while reset is held so every output reads 0
    assign if_gnt    = w_if_gnt && !rst;
    assign m_gnt     = w_m_gnt && !rst;
    assign if_rvalid = r_state == RESP && !r_owner;
    assign m_rvalid  = r_state == RESP && r_owner;
    assign if_rdata  = r_if_rdata;
    assign m_rdata   = r_m_rdata;
    assign ram_en    = r_state == ISSUE;
    assign ram_we    = r_state == ISSUE && r_we;
    assign ram_funct = r_funct;
    assign ram_addr  = r_addr;
    assign ram_wdata = r_wdata;
    assign busy      = r_state != IDLE;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed literal checks plus randomized traffic against a transaction-age model.
module tb_mem_port_arbiter;
    localparam int LAT = 3;
    localparam int SL  = 2;
    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        m_req;
    logic        m_we;
    logic [9:0]  m_funct;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_gnt;
    logic        m_rvalid;
    logic [31:0] m_rdata;
    logic        ram_en;
    logic        ram_we;
    logic [9:0]  ram_funct;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic        busy;
    int checks = 0;
    int errors = 0;
    mem_port_arbiter #(.RAM_LATENCY(LAT), .STARVE_LIMIT(SL)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .m_req(m_req), .m_we(m_we), .m_funct(m_funct), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_funct(ram_funct), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .busy(busy)
    );
    always #5 clk = ~clk;
    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask
    // Model: a transaction is described only by its age (cycles since the accepting cycle)
    bit          act, own, c_we, e_ig, e_mg, win, heavy, g_if, g_m;
    int          age, starve, n_forced, n_acc;
    logic [9:0]  c_funct;
    logic [31:0] c_addr, c_wdata, x_if, x_m;
    string       gord;
    int          gcyc[$];
    initial begin
        rst = 1'b1; if_req = 1'b1; m_req = 1'b1; if_addr = 32'h40; m_addr = 32'h80;
        m_we = 1'b0; m_funct = 10'd0; m_wdata = 32'd0; ram_rdata = 32'd0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_if_gnt", 32'(if_gnt), 0);
        chk("rst_m_gnt", 32'(m_gnt), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ram_en", 32'(ram_en), 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_m_rdata", m_rdata, 0);
        // load 0x100 returning DEADBEEF
        @(negedge clk); rst = 1'b0; if_req = 1'b0; m_req = 1'b1; m_we = 1'b0; m_funct = 10'h2a; m_addr = 32'h100; #1;
        chk("ld_m_gnt", 32'(m_gnt), 1);
        chk("ld_if_gnt", 32'(if_gnt), 0);
        @(negedge clk); m_req = 1'b0; #1;
        chk("ld_ram_en", 32'(ram_en), 1);
        chk("ld_ram_we", 32'(ram_we), 0);
        chk("ld_ram_addr", ram_addr, 32'h100);
        chk("ld_ram_funct", 32'(ram_funct), 32'h2a);
        chk("ld_busy", 32'(busy), 1);
        @(negedge clk); #1;
        chk("ld_ram_en_off", 32'(ram_en), 0);
        @(negedge clk); ram_rdata = 32'hDEADBEEF; #1;
        chk("ld_early_rvalid", 32'(m_rvalid), 0);
        @(negedge clk); ram_rdata = 32'h0; #1;
        chk("ld_m_rvalid", 32'(m_rvalid), 1);
        chk("ld_m_rdata", m_rdata, 32'hDEADBEEF);
        chk("ld_if_rvalid", 32'(if_rvalid), 0);
        // store 0x20 data 0x55AA, accepted in the response cycle's successor
        @(negedge clk); m_req = 1'b1; m_we = 1'b1; m_addr = 32'h20; m_wdata = 32'h55AA; #1;
        chk("st_idle_busy", 32'(busy), 0);
        chk("st_m_gnt", 32'(m_gnt), 1);
        @(negedge clk); m_req = 1'b0; #1;
        chk("st_ram_en", 32'(ram_en), 1);
        chk("st_ram_we", 32'(ram_we), 1);
        chk("st_ram_wdata", ram_wdata, 32'h55AA);
        @(negedge clk); #1;
        chk("st_ram_we_off", 32'(ram_we), 0);
        chk("st_busy2", 32'(busy), 1);
        @(negedge clk); ram_rdata = 32'h12345678; #1;
        @(negedge clk); ram_rdata = 32'h0; #1;
        chk("st_m_rvalid", 32'(m_rvalid), 1);
        chk("st_m_rdata_kept", m_rdata, 32'hDEADBEEF);
        chk("st_busy4", 32'(busy), 1);
        // contention: both held, expect m,m,i repeating with a grant every LAT+1 cycles
        gord = "";
        for (int c = 0; c < 6 * (LAT + 1); c++) begin
            @(negedge clk); m_req = 1'b1; m_we = 1'b0; if_req = 1'b1; #1;
            if (m_gnt) begin gord = {gord, "m"}; gcyc.push_back(c); end
            if (if_gnt) begin gord = {gord, "i"}; gcyc.push_back(c); end
        end
        chk("cont_order", (gord == "mmimmi") ? 32'd1 : 32'd0, 1);
        chk("cont_count", gcyc.size(), 6);
        for (int k = 0; k < gcyc.size(); k++) chk("cont_spacing", gcyc[k], k * (LAT + 1));
        @(negedge clk); if_req = 1'b0; m_req = 1'b0;
        repeat (2 * (LAT + 2)) @(negedge clk);
        // reset in the middle of a load's wait phase
        m_req = 1'b1; m_we = 1'b0; m_addr = 32'h300; #1;
        chk("rw_m_gnt", 32'(m_gnt), 1);
        @(negedge clk); m_req = 1'b0;
        @(negedge clk); if_req = 1'b1; if_addr = 32'h44; rst = 1'b1; #1;
        chk("rw_busy", 32'(busy), 0);
        chk("rw_m_rdata", m_rdata, 0);
        chk("rw_if_rdata", if_rdata, 0);
        chk("rw_if_gnt", 32'(if_gnt), 0);
        chk("rw_m_rvalid", 32'(m_rvalid), 0);
        @(negedge clk); rst = 1'b0; #1;
        chk("rw_first_if_gnt", 32'(if_gnt), 1);
        @(negedge clk); if_req = 1'b0; #1;
        chk("rw_ram_addr", ram_addr, 32'h44);
        for (int c = 0; c < LAT + 2; c++) begin
            @(negedge clk); #1;
            chk("rw_no_m_rvalid", 32'(m_rvalid), 0);
        end
        // randomized phase; begins with a reset so the model starts clean
        act = 0; age = 0; starve = 0; own = 0; c_we = 0; c_funct = '0; c_addr = '0; c_wdata = '0;
        x_if = '0; x_m = '0; g_if = 0; g_m = 0; n_forced = 0; n_acc = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            rst = (cyc == 0) || ($urandom_range(0, 299) == 0);
            heavy = ((cyc / 500) % 2) == 1;
            if (!if_req || g_if) begin
                if_req = heavy || ($urandom_range(0, 2) != 0);
                if_addr = $urandom;
            end else if ($urandom_range(0, 15) == 0) if_req = 1'b0;
            if (!m_req || g_m) begin
                m_req = heavy || ($urandom_range(0, 2) != 0);
                m_we = 1'($urandom_range(0, 1));
                m_funct = 10'($urandom_range(0, 1023));
                m_addr = $urandom;
                m_wdata = $urandom;
            end else if ($urandom_range(0, 15) == 0) m_req = 1'b0;
            ram_rdata = $urandom;
            #1;
            if (rst) begin
                act = 0; age = 0; starve = 0; own = 0; c_we = 0; c_funct = '0; c_addr = '0; c_wdata = '0;
                x_if = '0; x_m = '0;
            end
            win = !rst && (!act || age == LAT + 1);
            e_mg = win && m_req && !(if_req && starve == SL);
            e_ig = win && if_req && !e_mg;
            chk("m_gnt", 32'(m_gnt), 32'(e_mg));
            chk("if_gnt", 32'(if_gnt), 32'(e_ig));
            chk("ram_en", 32'(ram_en), 32'(act && age == 1));
            chk("ram_we", 32'(ram_we), 32'(act && age == 1 && c_we));
            chk("ram_addr", ram_addr, c_addr);
            chk("ram_funct", 32'(ram_funct), 32'(c_funct));
            chk("ram_wdata", ram_wdata, c_wdata);
            chk("if_rvalid", 32'(if_rvalid), 32'(act && age == LAT + 1 && !own));
            chk("m_rvalid", 32'(m_rvalid), 32'(act && age == LAT + 1 && own));
            chk("if_rdata", if_rdata, x_if);
            chk("m_rdata", m_rdata, x_m);
            chk("busy", 32'(busy), 32'(act));
            if (!rst) begin
                if (act && age == LAT) begin
                    if (!own) x_if = ram_rdata;
                    else if (!c_we) x_m = ram_rdata;
                end
                if (e_mg || e_ig) begin
                    n_acc++;
                    if (e_ig && m_req) n_forced++;
                    own = e_mg;
                    c_we = e_mg && m_we;
                    c_funct = e_mg ? m_funct : 10'd0;
                    c_addr = e_mg ? m_addr : if_addr;
                    c_wdata = e_mg ? m_wdata : 32'd0;
                    starve = e_ig ? 0 : (if_req ? ((starve + 1 > SL) ? SL : starve + 1) : starve);
                    act = 1; age = 1;
                end else if (act && age == LAT + 1) act = 0;
                else if (act) age++;
            end
            g_if = e_ig; g_m = e_mg;
        end
        chk("rand_accepts", (n_acc > 200) ? 32'd1 : 32'd0, 1);
        chk("rand_forced_fetch", (n_forced > 10) ? 32'd1 : 32'd0, 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
